ledctl_pwm: RTL
===============

Name: ledctl_pwm

Overview:
- Parametrised successor to the badge LED row/column multiplexer: drives ROWS one-hot anode lines and COLS cathode lines, time-sliced per row.
- Adds per-LED PWM brightness, a blanking gap between rows (anti-ghosting), frame-synchronous shadow latching (no tearing), an enable, and selectable cathode polarity.
- Sits between the SoC LED register block and the LED pins.

Parameters:
- ROWS, 3, number of anode rows (>=1)
- COLS, 11, number of cathode columns (>=1)
- PWM_BITS, 8, brightness width per LED (2..12); ON window per row is PWM_MAX = 2^PWM_BITS-1 cycles
- BLANK_CYCLES, 4, all-off cycles before each row's ON window (>=1)
- CATH_INV, 0, 1 = cathode outputs active-low; inactive level is CATH_INV

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  scan enable
- led_bri  in  ROWS*COLS*PWM_BITS  brightness; LED (r,c) at bits [(r*COLS+c)*PWM_BITS +: PWM_BITS]
- leda  out  ROWS  one-hot anode drive, active-high
- ledc  out  COLS  cathode drive, polarity per CATH_INV
- frame_start  out  1  one-cycle pulse when shadow latches new brightness

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE, row=0, counter=0, leda=0, ledc={COLS{CATH_INV}}, frame_start=0, shadow cleared to 0.
- All outputs registered.
- States: IDLE, BLANK, ON.
- IDLE: outputs inactive. en sampled high at edge e -> BLANK, row 0; frame_start=1 and shadow<=led_bri in cycle e+1 (call it t0).
- BLANK:
  - lasts BLANK_CYCLES cycles with leda=0 and ledc inactive.
  - then -> ON, counter=0.
- ON:
  - lasts PWM_MAX cycles, counter 0..PWM_MAX-1.
  - leda = 1<<row.
  - ledc[c] active iff shadow[row][c] > counter.
  - value 0: never lit. Value PWM_MAX: lit all PWM_MAX cycles.
- End of ON, row<ROWS-1: row++, -> BLANK.
- End of ON, row==ROWS-1: row=0, -> BLANK. This is a new frame: frame_start pulses and the shadow re-latches in that first BLANK cycle.
- Timing: frame period F = ROWS*(BLANK_CYCLES+PWM_MAX). Defaults give 3*(4+255)=777 cycles.
- Row r ON window: t0 + r*(B+PWM_MAX) + B … +PWM_MAX-1, where B = BLANK_CYCLES.
- leda never has more than one bit set. leda is never nonzero in the cycle before or after a row change, which the BLANK gap guarantees.
- led_bri changes mid-frame have no effect until the next frame_start.
- en low at any edge -> next cycle IDLE, outputs inactive, row/counter cleared. The shadow is kept but re-latched on restart.
- rst mid-scan: identical to power-on reset on the next cycle; rst dominates en.
- Counter widths: counter is PWM_BITS wide, row is $clog2(ROWS) wide (min 1). Comparison is unsigned.

Optional Feature:
- Macro LEDCTL_GAMMA_EN.
- Defined: each value is mapped at shadow-latch time as g = (v*v + PWM_MAX) >> PWM_BITS, unsigned, with the intermediate 2*PWM_BITS wide. Fixed points: 0->0, 1->1, PWM_MAX->PWM_MAX. At PWM_BITS=8: 16->1, 128->64.
- Undefined: shadow stores v unchanged.
- Timing, latency and ports are identical in both builds.

Decomposition:
- Package ledctl_pkg:
  - state enum (IDLE/BLANK/ON)
  - helper function for the PWM_MAX constant
  - gamma function
  - CNT/ROW width functions
- One sub-module, ledctl_gamma: combinational per-value map with parameter PWM_BITS, instantiated ROWS*COLS times only under LEDCTL_GAMMA_EN.
- Scan FSM, counter and compare stay in ledctl_pwm.

Test Plan:
- Reset/idle: rst=1 then en=0 for 2000 cycles -> leda=0, ledc=0 (CATH_INV=0), frame_start never high.
- Default params, all LEDs 255, en=1 -> frame_start every 777 cycles. Each row ON 255 consecutive cycles with ledc=11'h7FF, preceded by 4 cycles of leda=0/ledc=0. Rows sequence 001,010,100.
- Duty check: LED(1,3)=64, others 0 -> ledc[3] high exactly 64 cycles per frame, only while leda=010, in the first 64 cycles of that window. No other ledc bit ever set.
- Tearing: change led_bri mid-frame from 10 to 200 -> the current frame keeps 10 cycles/row; the next frame shows 200.
- Enable/reset mid-scan: drop en during a row-2 ON window -> next cycle all outputs inactive. Re-raise -> frame_start on the following cycle, row 0 first. Repeat with rst -> same.
- Gamma build (LEDCTL_GAMMA_EN) with CATH_INV=1: inputs 0,1,16,128,255 -> active-low pulse widths 0,1,1,64,255 cycles; idle ledc=11'h7FF.

Source files
------------

// File: rtl/ledctl_pkg.sv
// Shared types and helpers for the LED row/column PWM scanner.
// Gamma mapping is enabled in the top level with the LEDCTL_GAMMA_EN macro.
package ledctl_pkg;

    // Scan state: idle, inter-row blanking gap, row ON window.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_e;

    // Length of one row's ON window, also the full-scale brightness code.
    function automatic int pwm_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    // PWM counter width: one bit per brightness bit.
    function automatic int cnt_w(input int bits);
        return bits;
    endfunction

    // Index width for a count of n items, never below one bit.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Perceptual brightness curve g = (v*v + PWM_MAX) >> PWM_BITS.
    // Sized for the widest supported brightness (12 bits); callers truncate.
    function automatic logic [11:0] gamma_map(input logic [11:0] v, input int bits);
        logic [23:0] sq;
        sq = 24'(v) * 24'(v) + 24'(pwm_max(bits));
        return 12'(sq >> bits);
    endfunction

endpackage

// File: rtl/ledctl_gamma.sv
// Combinational gamma map for one brightness value.
module ledctl_gamma
    import ledctl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic [PWM_BITS-1:0] v,
    output logic [PWM_BITS-1:0] g
);

    // Result never exceeds PWM_MAX, so truncation to PWM_BITS is lossless.
    always_comb begin
        g = PWM_BITS'(gamma_map(12'(v), PWM_BITS));
    end

endmodule

// File: rtl/ledctl_pwm.sv
// Row-multiplexed LED matrix driver with per-LED PWM, blanking gap between
// rows and frame-synchronous shadow latching of brightness.
// Optional build macro: LEDCTL_GAMMA_EN (gamma-map values as they are latched).
module ledctl_pwm
    import ledctl_pkg::*;
#(
    parameter int ROWS         = 3,
    parameter int COLS         = 11,
    parameter int PWM_BITS     = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int CATH_INV     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [ROWS*COLS*PWM_BITS-1:0] led_bri,
    output logic [ROWS-1:0]               leda,
    output logic [COLS-1:0]               ledc,
    output logic                          frame_start
);

    localparam int RW = row_w(ROWS);
    localparam int CW = cnt_w(PWM_BITS);
    localparam int BW = row_w(BLANK_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(pwm_max(PWM_BITS) - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic          CINV     = (CATH_INV != 0);

    // Brightness after optional mapping, viewed as [row][col].
    logic [ROWS*COLS*PWM_BITS-1:0] bri_map;
    logic [PWM_BITS-1:0]           bri_arr [ROWS][COLS];

`ifdef LEDCTL_GAMMA_EN
    for (genvar gi = 0; gi < ROWS*COLS; gi++) begin : g_gamma
        ledctl_gamma #(.PWM_BITS(PWM_BITS)) u_gamma (
            .v (led_bri[gi*PWM_BITS +: PWM_BITS]),
            .g (bri_map[gi*PWM_BITS +: PWM_BITS])
        );
    end
`else
    assign bri_map = led_bri;
`endif

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            assign bri_arr[gi][gc] = bri_map[(gi*COLS+gc)*PWM_BITS +: PWM_BITS];
        end
    end

    state_e              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       blk_q, blk_d;
    logic [PWM_BITS-1:0] shadow_q [ROWS][COLS];
    logic [PWM_BITS-1:0] shadow_d [ROWS][COLS];
    logic [ROWS-1:0]     leda_q, leda_d;
    logic [COLS-1:0]     ledc_q, ledc_d;
    logic                fs_q, fs_d;

    // Next scan state, shadow latch and registered output values.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        blk_d    = blk_q;
        shadow_d = shadow_q;
        fs_d     = 1'b0;
        leda_d   = '0;
        ledc_d   = {COLS{CINV}};

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = BLANK;
                    row_d    = '0;
                    cnt_d    = '0;
                    blk_d    = '0;
                    fs_d     = 1'b1;
                    shadow_d = bri_arr;
                end
            end
            BLANK: begin
                if (blk_q == BLK_LAST) begin
                    state_d = ON;
                    cnt_d   = '0;
                    blk_d   = '0;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            ON: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    blk_d   = '0;
                    if (row_q == RW'(ROWS - 1)) begin
                        // Wrap to row 0 starts a new frame.
                        row_d    = '0;
                        fs_d     = 1'b1;
                        shadow_d = bri_arr;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable stops the scan; the shadow is kept and re-latched on restart.
        if (!en) begin
            state_d = IDLE;
            row_d   = '0;
            cnt_d   = '0;
            blk_d   = '0;
            fs_d    = 1'b0;
        end

        // ON windows never coincide with a shadow latch, so shadow_q is current.
        if (state_d == ON) begin
            leda_d = ROWS'(1) << row_d;
            for (int c = 0; c < COLS; c++) begin
                ledc_d[c] = (shadow_q[row_d][c] > cnt_d) ? ~CINV : CINV;
            end
        end
    end

    // State, counters, shadow and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            blk_q   <= '0;
            leda_q  <= '0;
            ledc_q  <= {COLS{CINV}};
            fs_q    <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    shadow_q[r][c] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            blk_q    <= blk_d;
            leda_q   <= leda_d;
            ledc_q   <= ledc_d;
            fs_q     <= fs_d;
            shadow_q <= shadow_d;
        end
    end

    assign leda        = leda_q;
    assign ledc        = ledc_q;
    assign frame_start = fs_q;

endmodule
